cpu_step_ctrl: RTL and testbench

- Upstream clock-enable generator for the R-type CPU test top.
- Turns a raw push-button into exactly one debounced CPU step pulse per press, or in run mode emits a periodic enable.
- Keeps a step counter for display.
- Its cpu_en output gates the CPU register updates, so one press advances the board by one instruction.

---
 rtl/cpu_step_ctrl.sv | 81 ++++++++
 tb/tb_cpu_step_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: debounced single-step / free-run clock-enable generator for the CPU.
// Each accepted press gives one cpu_en pulse; run mode gives one every RUN_DIV cycles.
module cpu_step_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20,
  parameter int RUN_DIV    = 50000000,
  parameter int DIV_W      = 26,
  parameter int STEP_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step,
  input  logic              sw_run,
  output logic              cpu_en,
  output logic [STEP_W-1:0] step_cnt,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_DEB_PRESS = 2'b01,
    S_PULSE     = 2'b10,
    S_WAIT_REL  = 2'b11
  } state_t;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  state_t            state;
  logic [1:0]        btn_q, run_q;
  logic [DEB_W-1:0]  deb_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              btn_s, run_s;
  assign btn_s     = btn_q[1];
  assign run_s     = run_q[1];
  assign state_dbg = state;
  // cpu_en and step_cnt are updated on the same edge, so step_cnt already counts the visible pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= S_IDLE;
      btn_q    <= '0;
      run_q    <= '0;
      deb_cnt  <= '0;
      div_cnt  <= '0;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      btn_q  <= {btn_q[0], btn_step};
      run_q  <= {run_q[0], sw_run};
      cpu_en <= 1'b0;
      case (state)
        S_IDLE:
          if (run_s) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt  <= '0;
              cpu_en   <= 1'b1;
              step_cnt <= step_cnt + 1'b1;
            end else div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (btn_s) begin
              state   <= S_DEB_PRESS;
              deb_cnt <= '0;
            end
          end
        S_DEB_PRESS:
          if (!btn_s) state <= S_IDLE;
          else if (deb_cnt == DEB_LAST) begin
            state    <= S_PULSE;
            cpu_en   <= 1'b1;
            step_cnt <= step_cnt + 1'b1;
          end else deb_cnt <= deb_cnt + 1'b1;
        S_PULSE: begin
          state   <= S_WAIT_REL;
          deb_cnt <= '0;
        end
        S_WAIT_REL:
          if (btn_s) deb_cnt <= '0;
          else if (deb_cnt == DEB_LAST) state <= S_IDLE;
          else deb_cnt <= deb_cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and random stimulus checked cycle by cycle against a phase/counter model.
module tb_cpu_step_ctrl;
  localparam int DEB = 4, DIV = 5, SW = 4;
  localparam int P_IDLE = 0, P_PRESS = 1, P_PULSE = 2, P_REL = 3;
  logic          clk = 1'b0, rst = 1'b0, btn_step = 1'b0, sw_run = 1'b0;
  logic          cpu_en;
  logic [SW-1:0] step_cnt;
  logic [1:0]    state_dbg;
  int passed = 0, total = 0;
  int ph, stable, run_age, pulses;
  logic [1:0] sb, sr;
  logic m_en, prev_en;

  cpu_step_ctrl #(.DEB_CYCLES(DEB), .DEB_W(2), .RUN_DIV(DIV), .DIV_W(3), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .sw_run(sw_run),
    .cpu_en(cpu_en), .step_cnt(step_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Model: 'stable' counts consecutive qualifying cycles in the press/release phases,
  // 'run_age' counts run-mode cycles; pulses is the unbounded step count reduced mod 2^SW.
  task automatic model_reset();
    ph = P_IDLE; stable = 0; run_age = 0; pulses = 0; sb = 2'b00; sr = 2'b00; m_en = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic r);
    logic bs, rs;
    bs = sb[1]; rs = sr[1];
    m_en = 1'b0;
    if (!rst) model_reset();
    else begin
      if (ph == P_IDLE) begin
        if (rs) begin
          run_age++;
          if (run_age % DIV == 0) begin m_en = 1'b1; pulses++; end
        end else begin
          run_age = 0;
          if (bs) begin ph = P_PRESS; stable = 0; end
        end
      end else if (ph == P_PRESS) begin
        if (!bs) ph = P_IDLE;
        else begin
          stable++;
          if (stable == DEB) begin ph = P_PULSE; m_en = 1'b1; pulses++; end
        end
      end else if (ph == P_PULSE) begin
        ph = P_REL; stable = 0;
      end else begin
        if (bs) stable = 0;
        else begin
          stable++;
          if (stable == DEB) ph = P_IDLE;
        end
      end
      sb = {sb[0], b}; sr = {sr[0], r};
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
  endtask

  task automatic chk_all();
    chk("cpu_en", int'(cpu_en), int'(m_en));
    chk("step_cnt", int'(step_cnt), pulses % (1 << SW));
    chk("state_dbg", int'(state_dbg), ph);
    chk("en_gap", int'(prev_en & cpu_en), 0);
    prev_en = cpu_en;
  endtask

  task automatic cyc(input logic b, input logic r);
    btn_step = b; sw_run = r;
    @(posedge clk);
    model_step(b, r);
    @(negedge clk);
    chk_all();
  endtask

  task automatic hold(input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) cyc(b, r);
  endtask

  initial begin
    model_reset();
    prev_en = 1'b0;
    // reset held with button pressed
    hold(1, 0, 3);
    rst = 1'b1;
    hold(1, 0, 12);
    chk("reset_then_one_pulse", pulses, 1);
    hold(0, 0, 8);
    // clean press
    hold(1, 0, 20);
    hold(0, 0, 10);
    chk("clean_press_count", pulses, 2);
    // press bounce then hold, then a lone glitch
    for (int i = 0; i < 3; i++) begin hold(1, 0, 2); hold(0, 0, 1); end
    hold(1, 0, 10);
    hold(0, 0, 8);
    hold(1, 0, 3);
    hold(0, 0, 8);
    chk("bounce_glitch_count", pulses, 3);
    // release bounce
    hold(1, 0, 8);
    for (int i = 0; i < 4; i++) begin hold(0, 0, 2); hold(1, 0, 1); end
    chk("rel_bounce_state", int'(state_dbg), 3);
    hold(0, 0, 8);
    chk("rel_bounce_count", pulses, 4);
    // run mode, then drop and restart to expose a stale divider
    hold(0, 1, 27);
    hold(0, 0, 8);
    chk("run_count", pulses, 9);
    hold(0, 1, 9);
    hold(0, 0, 6);
    // sixteen steps wrap the counter
    for (int i = 0; i < 16; i++) begin hold(1, 0, 7); hold(0, 0, 8); end
    chk("wrap_count", pulses, 26);
    // async reset mid debounce
    hold(1, 0, 4);
    chk("mid_press_state", int'(state_dbg), 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_state", int'(state_dbg), 0);
    chk("async_cnt", int'(step_cnt), 0);
    chk("async_en", int'(cpu_en), 0);
    @(negedge clk);
    hold(1, 0, 2);
    rst = 1'b1;
    hold(0, 0, 10);
    chk("post_reset_count", pulses, 0);
    // random mix of presses, bounces and run intervals
    for (int s = 0; s < 80; s++) begin
      logic b, r;
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 5) == 0);
      hold(b, r, $urandom_range(1, 12));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
